// File: rtl/sa_cache_if.sv
// CPU-side request/response and memory-side line transfer signals of the
// set-associative cache; slave modport is the cache, master is its user.
interface sa_cache_if #(
  parameter int TAG_W    = 8,
  parameter int INDEX_W  = 4,
  parameter int OFFSET_W = 2,
  parameter int WORD_W   = 32
);
  localparam int LINE_W = WORD_W * (2 ** OFFSET_W);

  logic                       i_req;
  logic                       i_rw;
  logic [TAG_W-1:0]           i_tag;
  logic [INDEX_W-1:0]         i_index;
  logic [OFFSET_W-1:0]        i_offset;
  logic [WORD_W-1:0]          i_data_w;
  logic [WORD_W-1:0]          o_data;
  logic                       o_ready;
  logic                       o_done;
  logic                       o_hit;
  logic                       o_mem_req;
  logic                       o_mem_we;
  logic [TAG_W+INDEX_W-1:0]   o_mem_addr;
  logic [LINE_W-1:0]          o_mem_line;
  logic [LINE_W-1:0]          i_memory_line;
  logic                       i_memory_response;

  modport slave (
    input  i_req, i_rw, i_tag, i_index, i_offset, i_data_w,
    input  i_memory_line, i_memory_response,
    output o_data, o_ready, o_done, o_hit,
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_line
  );

  modport master (
    output i_req, i_rw, i_tag, i_index, i_offset, i_data_w,
    output i_memory_line, i_memory_response,
    input  o_data, o_ready, o_done, o_hit,
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_line
  );
endinterface

// File: rtl/sa_cache.sv
// 4-way set-associative write-back/write-allocate cache with age-based LRU.
// Define SA_CACHE_STATS_EN to add saturating hit/miss counters.
module sa_cache #(
  parameter int TAG_W    = 8,
  parameter int INDEX_W  = 4,
  parameter int OFFSET_W = 2,
  parameter int WORD_W   = 32
) (
  input  logic        clk,
  input  logic        rst,
  sa_cache_if.slave   bus
`ifdef SA_CACHE_STATS_EN
  ,
  output logic [15:0] o_hit_count,
  output logic [15:0] o_miss_count
`endif
);
  localparam int WAYS   = 4;
  localparam int SETS   = 2 ** INDEX_W;
  localparam int LINE_W = WORD_W * (2 ** OFFSET_W);

  typedef enum logic [2:0] {IDLE, LOOKUP, WB, FILL, DONE} state_t;
  state_t state, state_nx;

  logic                valid    [WAYS][SETS];
  logic                dirty    [WAYS][SETS];
  logic [1:0]          age      [WAYS][SETS];
  logic [TAG_W-1:0]    tag_mem  [WAYS][SETS];
  logic [LINE_W-1:0]   line_mem [WAYS][SETS];

  logic                r_rw;
  logic [TAG_W-1:0]    r_tag;
  logic [INDEX_W-1:0]  r_index;
  logic [OFFSET_W-1:0] r_offset;
  logic [WORD_W-1:0]   r_data;
  logic [1:0]          r_way;

  logic                hit;
  logic [1:0]          hit_way;
  logic [1:0]          victim;
  logic                found_free;
  logic [1:0]          acc_way;
  logic                touch;
  logic [LINE_W-1:0]   cur_line;
  logic [LINE_W-1:0]   new_line;
  logic [WORD_W-1:0]   new_word;

  function automatic logic [LINE_W-1:0] merge(input logic [LINE_W-1:0] line,
                                              input logic [OFFSET_W-1:0] off,
                                              input logic [WORD_W-1:0] word,
                                              input logic en);
    logic [LINE_W-1:0] m;
    m = line;
    if (en) m[int'(off)*WORD_W +: WORD_W] = word;
    return m;
  endfunction

  always_comb begin
    hit        = 1'b0;
    hit_way    = '0;
    victim     = '0;
    found_free = 1'b0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid[w][r_index] && tag_mem[w][r_index] == r_tag) begin
        hit     = 1'b1;
        hit_way = 2'(w);
      end
    end
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!found_free && !valid[w][r_index]) begin
        victim     = 2'(w);
        found_free = 1'b1;
      end
    end
    if (!found_free) begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (age[w][r_index] == 2'd3) victim = 2'(w);
      end
    end
  end

  // A hit is serviced in LOOKUP from the stored line; a miss in FILL from the bus.
  always_comb begin
    acc_way  = (state == LOOKUP) ? hit_way : r_way;
    cur_line = (state == LOOKUP) ? line_mem[hit_way][r_index] : bus.i_memory_line;
    new_line = merge(cur_line, r_offset, r_data, r_rw);
    new_word = new_line[int'(r_offset)*WORD_W +: WORD_W];
    touch    = (state == LOOKUP && hit) || (state == FILL && bus.i_memory_response);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.i_req) state_nx = LOOKUP;
      LOOKUP:  if (hit)                                        state_nx = DONE;
               else if (valid[victim][r_index] && dirty[victim][r_index]) state_nx = WB;
               else                                             state_nx = FILL;
      WB:      if (bus.i_memory_response) state_nx = FILL;
      FILL:    if (bus.i_memory_response) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        for (int unsigned s = 0; s < SETS; s++) begin
          valid[w][s] <= 1'b0;
          dirty[w][s] <= 1'b0;
          age[w][s]   <= 2'(w);
        end
      end
      r_way      <= '0;
      bus.o_data <= '0;
      bus.o_hit  <= 1'b0;
    end else begin
      if (state == LOOKUP) r_way <= hit ? hit_way : victim;
      if (touch) begin
        bus.o_data               <= new_word;
        bus.o_hit                <= (state == LOOKUP);
        valid[acc_way][r_index]  <= 1'b1;
        if (state == FILL) dirty[acc_way][r_index] <= r_rw;
        else if (r_rw)     dirty[acc_way][r_index] <= 1'b1;
        // Ages stay a permutation: only ways younger than the touched one shift up.
        for (int unsigned w = 0; w < WAYS; w++) begin
          if (2'(w) == acc_way)
            age[w][r_index] <= 2'd0;
          else if (age[w][r_index] < age[acc_way][r_index])
            age[w][r_index] <= age[w][r_index] + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && bus.i_req) begin
      r_rw     <= bus.i_rw;
      r_tag    <= bus.i_tag;
      r_index  <= bus.i_index;
      r_offset <= bus.i_offset;
      r_data   <= bus.i_data_w;
    end
    if (touch) begin
      line_mem[acc_way][r_index] <= new_line;
      tag_mem[acc_way][r_index]  <= r_tag;
    end
  end

  always_comb begin
    bus.o_ready    = (state == IDLE);
    bus.o_done     = (state == DONE);
    bus.o_mem_req  = (state == WB) || (state == FILL);
    bus.o_mem_we   = (state == WB);
    bus.o_mem_addr = (state == WB) ? {tag_mem[r_way][r_index], r_index} : {r_tag, r_index};
    bus.o_mem_line = line_mem[r_way][r_index];
  end

`ifdef SA_CACHE_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_hit_count  <= '0;
      o_miss_count <= '0;
    end else if (state == DONE) begin
      if (bus.o_hit) begin
        if (o_hit_count != '1) o_hit_count <= o_hit_count + 16'd1;
      end else begin
        if (o_miss_count != '1) o_miss_count <= o_miss_count + 16'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_sa_cache.sv
// Scoreboard bench for sa_cache: an MRU-ordered per-set model predicts
// responses and memory traffic; monitors compare as the DUT presents them.
module tb_sa_cache;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sa_cache_if #(.TAG_W(8), .INDEX_W(4), .OFFSET_W(2), .WORD_W(32)) bus ();

`ifdef SA_CACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
  sa_cache #(.TAG_W(8), .INDEX_W(4), .OFFSET_W(2), .WORD_W(32)) dut (
    .clk(clk), .rst(rst), .bus(bus), .o_hit_count(hit_count), .o_miss_count(miss_count));
`else
  sa_cache #(.TAG_W(8), .INDEX_W(4), .OFFSET_W(2), .WORD_W(32)) dut (
    .clk(clk), .rst(rst), .bus(bus));
`endif

  typedef struct {logic [7:0] tag; logic [127:0] line; bit dirty;} ent_t;
  typedef struct {bit hit; bit rd; logic [31:0] data; int acc;} rsp_t;
  typedef struct {bit we; logic [11:0] addr; logic [127:0] line;} mop_t;

  ent_t         sets [16][$];
  rsp_t         rsp_q [$];
  mop_t         mop_q [$];
  logic [127:0] ref_mem [logic [11:0]];
  logic [127:0] bus_mem [logic [11:0]];

  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  bit   hold_mem   = 1'b0;
  logic [11:0] last_fill = '0;
  logic [11:0] last_wb   = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void fail_now(string name);
    compared++;
    mismatched++;
    $display("FAIL %s (t=%0t)", name, $time);
  endfunction

  function automatic logic [127:0] pattern(logic [11:0] a);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) l[k*32 +: 32] = {a, 4'(k), 16'(a * 12'd2731) ^ 16'h5A5A};
    return l;
  endfunction

  function automatic logic [127:0] ref_get(logic [11:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : pattern(a);
  endfunction

  function automatic logic [127:0] bus_get(logic [11:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : pattern(a);
  endfunction

  // Reference: each set is a recency list (front = most recent), at most 4 lines.
  function automatic void model_access(bit rw, logic [7:0] t, logic [3:0] ix,
                                       logic [1:0] off, logic [31:0] wd, int acc);
    int   pos;
    ent_t e;
    ent_t v;
    rsp_t r;
    mop_t m;
    pos = -1;
    for (int i = 0; i < sets[ix].size(); i++) if (sets[ix][i].tag == t) pos = i;
    if (pos >= 0) begin
      e = sets[ix][pos];
      sets[ix].delete(pos);
      r.hit = 1'b1;
    end else begin
      r.hit = 1'b0;
      if (sets[ix].size() == 4) begin
        v = sets[ix].pop_back();
        if (v.dirty) begin
          ref_mem[{v.tag, ix}] = v.line;
          m.we = 1'b1; m.addr = {v.tag, ix}; m.line = v.line;
          mop_q.push_back(m);
        end
      end
      m.we = 1'b0; m.addr = {t, ix}; m.line = '0;
      mop_q.push_back(m);
      e.tag = t; e.line = ref_get({t, ix}); e.dirty = 1'b0;
    end
    if (rw) begin
      e.line[int'(off)*32 +: 32] = wd;
      e.dirty = 1'b1;
    end
    r.data = e.line[int'(off)*32 +: 32];
    r.rd   = !rw;
    r.acc  = acc;
    sets[ix].push_front(e);
    rsp_q.push_back(r);
  endfunction

  task automatic issue(bit rw, logic [7:0] t, logic [3:0] ix, logic [1:0] off, logic [31:0] wd);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.o_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.o_ready) begin
      fail_now("ready_timeout");
      return;
    end
    bus.i_req = 1'b1; bus.i_rw = rw; bus.i_tag = t; bus.i_index = ix;
    bus.i_offset = off; bus.i_data_w = wd;
    model_access(rw, t, ix, off, wd, cyc + 1);
    @(negedge clk);
    bus.i_req = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((rsp_q.size() != 0 || !bus.o_ready) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (rsp_q.size() != 0) fail_now("completion_timeout");
  endtask

  // Response monitor
  initial begin
    rsp_t r;
    forever begin
      @(negedge clk);
      if (rst && bus.o_done) begin
        if (rsp_q.size() == 0) fail_now("unexpected_done");
        else begin
          r = rsp_q.pop_front();
          chk("hit", 128'(bus.o_hit), 128'(r.hit));
          if (r.rd) chk("rdata", 128'(bus.o_data), 128'(r.data));
          // Done seen one edge after acceptance: registered at the second edge.
          if (r.hit) chk("hit_latency", 128'(cyc - r.acc), 128'(1));
        end
      end
    end
  end

  // Memory monitor and responder
  initial begin
    mop_t m;
    int   d;
    bus.i_memory_response = 1'b0;
    bus.i_memory_line     = '0;
    forever begin
      @(negedge clk);
      if (rst && bus.o_mem_req) begin
        if (mop_q.size() == 0) fail_now("unexpected_mem_req");
        else begin
          m = mop_q.pop_front();
          chk("mem_we", 128'(bus.o_mem_we), 128'(m.we));
          chk("mem_addr", 128'(bus.o_mem_addr), 128'(m.addr));
          if (m.we) chk("wb_line", bus.o_mem_line, m.line);
        end
        if (bus.o_mem_we) last_wb = bus.o_mem_addr;
        else              last_fill = bus.o_mem_addr;
        d = $urandom_range(0, 3);
        repeat (d) @(negedge clk);
        while (hold_mem) @(negedge clk);
        if (rst && bus.o_mem_req) begin
          if (bus.o_mem_we) bus_mem[bus.o_mem_addr] = bus.o_mem_line;
          else              bus.i_memory_line = bus_get(bus.o_mem_addr);
          bus.i_memory_response = 1'b1;
          @(negedge clk);
          bus.i_memory_response = 1'b0;
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] l;
    int n;
    bus.i_req = 1'b0; bus.i_rw = 1'b0; bus.i_tag = '0; bus.i_index = '0;
    bus.i_offset = '0; bus.i_data_w = '0;
    l = pattern(12'h123);
    l[63:32] = 32'hDEADBEEF;
    ref_mem[12'h123] = l;
    bus_mem[12'h123] = l;

    repeat (3) @(negedge clk);
    chk("rst_ready", 128'(bus.o_ready), 128'(1));
    chk("rst_done", 128'(bus.o_done), 128'(0));
    chk("rst_hit", 128'(bus.o_hit), 128'(0));
    chk("rst_data", 128'(bus.o_data), 128'(0));
    chk("rst_mem_req", 128'(bus.o_mem_req), 128'(0));
    chk("rst_mem_we", 128'(bus.o_mem_we), 128'(0));
    rst = 1'b1;

    issue(1'b0, 8'h12, 4'd3, 2'd1, '0);
    wait_idle();
    chk("first_fill_addr", 128'(last_fill), 128'(12'h123));
    issue(1'b0, 8'h12, 4'd3, 2'd1, '0);
    issue(1'b1, 8'h12, 4'd3, 2'd1, 32'hCAFEF00D);
    issue(1'b0, 8'h12, 4'd3, 2'd1, '0);
    for (int t = 8'h20; t <= 8'h23; t++) issue(1'b0, 8'(t), 4'd3, 2'($urandom_range(0, 3)), '0);
    wait_idle();
    chk("wb_addr", 128'(last_wb), 128'(12'h123));
    l = bus_get(12'h123);
    chk("wb_word1", 128'(l[63:32]), 128'(32'hCAFEF00D));

    // Abort a fill with reset, then confirm the cache came back empty.
    hold_mem = 1'b1;
    issue(1'b0, 8'h30, 4'd5, 2'd0, '0);
    n = 0;
    while (!(bus.o_mem_req && !bus.o_mem_we) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("fill_before_reset", 128'(bus.o_mem_req && !bus.o_mem_we), 128'(1));
    #1 rst = 1'b0;
    #1 chk("reset_mem_req", 128'(bus.o_mem_req), 128'(0));
    chk("reset_done", 128'(bus.o_done), 128'(0));
    for (int s = 0; s < 16; s++) sets[s].delete();
    rsp_q.delete();
    mop_q.delete();
    @(negedge clk);
    rst = 1'b1;
    #1 chk("ready_after_reset", 128'(bus.o_ready), 128'(1));
    hold_mem = 1'b0;
    repeat (4) @(negedge clk);
    issue(1'b0, 8'h23, 4'd3, 2'd2, '0);
    issue(1'b0, 8'h12, 4'd3, 2'd1, '0);
    wait_idle();

    for (int i = 0; i < 400; i++)
      issue(1'($urandom_range(0, 1)), 8'($urandom_range(0, 9)), 4'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), $urandom);
    wait_idle();
    chk("rsp_q_drained", 128'(rsp_q.size()), 128'(0));
    chk("mop_q_drained", 128'(mop_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
